// File: rtl/ks_pipe_sub.sv
// Pipelined Kogge-Stone subtractor: diff = a - b - bin with a valid/ready pipeline of level+2 stages.
// Define KS_SUB_OVF_EN to add the registered two's-complement overflow output ovf.
module ks_pipe_sub #(
  parameter int size  = 16,
  parameter int level = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [size:1] a,
  input  logic [size:1] b,
  input  logic          bin,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [size:1] diff,
  output logic          bout
`ifdef KS_SUB_OVF_EN
  ,
  output logic          ovf
`endif
);

  logic          en;
  logic [size:1] p_in, g_in;

  // Prefix network state: position 0 is the carry-in (g = ~bin, p = 0),
  // positions 1..size-1 are the operand bits below the MSB.
  logic [size-1:0] gs [0:level];
  logic [size-1:0] ps [0:level-1];
  logic [size-1:0] gn [1:level];
  logic [size-1:0] pn [1:level-1];

  // Bitwise propagate for the sum and the MSB generate ride along unmodified.
  logic [size:1]   xp [0:level];
  logic [level:0]  xg;
  logic [level:0]  vld;

`ifdef KS_SUB_OVF_EN
  logic [level:0]  sa, sb;
`endif

  assign en       = ~out_valid | out_ready;
  // Operands seen during reset are dropped, so the block always looks ready then.
  assign in_ready = en | ~rst_n;

  assign p_in = a ^ ~b;
  assign g_in = a & ~b;

  for (genvar m = 1; m <= level; m++) begin : g_lvl
    for (genvar i = 0; i < size; i++) begin : g_bit
      if (i >= (1 << (m - 1))) begin : g_op
        assign gn[m][i] = gs[m-1][i] | (ps[m-1][i] & gs[m-1][i-(1<<(m-1))]);
        if (m < level) begin : g_p
          assign pn[m][i] = ps[m-1][i] & ps[m-1][i-(1<<(m-1))];
        end
      end else begin : g_pass
        assign gn[m][i] = gs[m-1][i];
        if (m < level) begin : g_p
          assign pn[m][i] = ps[m-1][i];
        end
      end
    end
  end

  // NOTE: datapath registers carry no reset; the valid bits alone decide whether
  // their contents mean anything, which keeps reset fan-out off the wide buses.
  always_ff @(posedge clk) begin
    if (en) begin
      gs[0] <= {g_in[size-1:1], ~bin};
      ps[0] <= {p_in[size-1:1], 1'b0};
      xp[0] <= p_in;
      xg[0] <= g_in[size];
`ifdef KS_SUB_OVF_EN
      sa[0] <= a[size];
      sb[0] <= b[size];
`endif
      for (int k = 1; k <= level; k++) begin
        gs[k] <= gn[k];
        xp[k] <= xp[k-1];
        xg[k] <= xg[k-1];
`ifdef KS_SUB_OVF_EN
        sa[k] <= sa[k-1];
        sb[k] <= sb[k-1];
`endif
      end
      for (int k = 1; k < level; k++) begin
        ps[k] <= pn[k];
      end
    end
  end

  // gs[level][i] is the carry out of bit i; the MSB carry is resolved here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld       <= '0;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
`ifdef KS_SUB_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (en) begin
      vld       <= {vld[level-1:0], in_valid};
      out_valid <= vld[level];
      diff      <= xp[level] ^ gs[level];
      bout      <= ~(xg[level] | (xp[level][size] & gs[level][size-1]));
`ifdef KS_SUB_OVF_EN
      ovf       <= (sa[level] ^ sb[level]) &
                   (sa[level] ^ xp[level][size] ^ gs[level][size-1]);
`endif
    end
  end

endmodule

// File: tb/tb_ks_pipe_sub.sv
// Scoreboard bench for ks_pipe_sub: directed vectors, stalls, mid-flight reset and random traffic.
module tb_ks_pipe_sub;
  localparam int SIZE  = 16;
  localparam int LEVEL = 4;

  logic            clk = 1'b0;
  logic            rst_n, in_valid, in_ready, bin, out_valid, out_ready, bout;
  logic [SIZE:1]   a, b, diff;
  logic            dut_ovf;

  typedef struct packed {
    logic          ovf;
    logic          bout;
    logic [SIZE:1] diff;
  } res_t;

  res_t exp_q[$];
  int   checks = 0, failures = 0;
  int   acc_cnt = 0, out_cnt = 0, dropped = 0;

  always #5 clk = ~clk;

`ifdef KS_SUB_OVF_EN
  logic ovf;
  assign dut_ovf = ovf;
`else
  assign dut_ovf = 1'b0;
`endif

  ks_pipe_sub #(.size(SIZE), .level(LEVEL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout)
`ifdef KS_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  function automatic res_t model(input logic [SIZE:1] ai, input logic [SIZE:1] bi, input logic bi_n);
    logic [SIZE+1:1] full;
    res_t r;
    full   = {1'b0, ai} - {1'b0, bi} - {{SIZE{1'b0}}, bi_n};
    r.diff = full[SIZE:1];
    r.bout = full[SIZE+1];
`ifdef KS_SUB_OVF_EN
    r.ovf  = (ai[SIZE] != bi[SIZE]) && (r.diff[SIZE] != ai[SIZE]);
`else
    r.ovf  = 1'b0;
`endif
    return r;
  endfunction

  // Scoreboard monitor: samples on the falling edge, away from the active edge.
  logic prev_stall = 1'b0;
  res_t prev_res;
  always @(negedge clk) begin
    res_t act, e;
    act = {dut_ovf, bout, diff};
    if (rst_n !== 1'b1) begin
      dropped += exp_q.size();
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || act !== prev_res) begin
          failures++;
          $display("FAIL stall_hold: got valid=%b res=%h, required valid=1 res=%h", out_valid, act, prev_res);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        out_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output: got res=%h, required no output", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL result: got ovf=%b bout=%b diff=%h, required ovf=%b bout=%b diff=%h",
                     act.ovf, act.bout, act.diff, e.ovf, e.bout, e.diff);
          end
        end
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_res   = act;
      if (in_valid && in_ready === 1'b1) begin
        acc_cnt++;
        exp_q.push_back(model(a, b, bin));
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    int n;
    n = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; a = 16'h0005; b = 16'h0003; bin = 1'b0;
    step(); step();
    checks++;
    if (out_valid !== 1'b0 || diff !== '0 || bout !== 1'b0 || dut_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got valid=%b diff=%h bout=%b ovf=%b, required all 0", out_valid, diff, bout, dut_ovf);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    repeat (8) step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_accept: got out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_latency(input logic [SIZE:1] ai, input logic [SIZE:1] bi, input logic bi_n, input string name);
    int   cyc;
    res_t e;
    e = model(ai, bi, bi_n);
    out_ready = 1'b1;
    a = ai; b = bi; bin = bi_n; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    checks++;
    if (cyc != LEVEL + 2) begin
      failures++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", name, cyc, LEVEL + 2);
    end
    checks++;
    if (diff !== e.diff || bout !== e.bout) begin
      failures++;
      $display("FAIL %s_value: got diff=%h bout=%b, required diff=%h bout=%b", name, diff, bout, e.diff, e.bout);
    end
    drain();
  endtask

  task automatic test_vectors;
    logic [SIZE:1] va [10] = '{16'h0000, 16'h0005, 16'h8000, 16'h7FFF, 16'hFFFF,
                               16'h0000, 16'hFFFF, 16'h8000, 16'h1234, 16'h7FFF};
    logic [SIZE:1] vb [10] = '{16'h0001, 16'h0005, 16'h0001, 16'hFFFF, 16'hFFFF,
                               16'hFFFF, 16'h0000, 16'h8000, 16'h1234, 16'h8000};
    logic          vc [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = va[i]; b = vb[i]; bin = vc[i]; in_valid = 1'b1;
      step();
    end
    drain();
  endtask

  task automatic test_back_to_back;
    int cyc, i, n0;
    cyc = 0; i = 1;
    n0 = out_cnt;
    while ((i <= 8 || exp_q.size() != 0) && cyc < 60) begin
      step();
      cyc++;
      out_ready = !(cyc >= 7 && cyc <= 9);
      in_valid  = (i <= 8);
      a = i[SIZE-1:0]; b = 16'h0001; bin = 1'b0;
      #1;
      if (cyc >= 7 && cyc <= 9) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL stall_in_ready: cycle %0d got %b, required 0", cyc, in_ready);
        end
      end
      if (in_valid && in_ready) i++;
    end
    in_valid = 1'b0;
    drain();
    checks++;
    if (out_cnt - n0 != 8) begin
      failures++;
      $display("FAIL b2b_count: got %0d results, required 8", out_cnt - n0);
    end
  endtask

  task automatic test_reset_midflight;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 16'h0100 + i; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
      step();
    end
    rst_n = 1'b0;
    a = 16'h0009; b = 16'h0002;
    step();
    rst_n = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush: cycle %0d got out_valid=%b, required 0", i, out_valid);
      end
      step();
    end
    test_latency(16'h0040, 16'h0041, 1'b0, "post_reset");
  endtask

  task automatic test_random;
    int n_acc, cyc;
    n_acc = 0; cyc = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      step();
      cyc++;
      in_valid  = ($urandom_range(9) < 7);
      out_ready = ($urandom_range(9) < 7);
      a   = $urandom();
      b   = $urandom();
      bin = $urandom_range(1);
      #1;
      if (in_valid && in_ready) n_acc++;
    end
    in_valid = 1'b0;
    checks++;
    if (n_acc < 10000) begin
      failures++;
      $display("FAIL random_budget: got %0d accepted, required 10000", n_acc);
    end
    drain();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; bin = 1'b0;
    test_reset();
    test_latency(16'h0005, 16'h0003, 1'b0, "basic");
    test_vectors();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    checks++;
    if (out_cnt + dropped != acc_cnt) begin
      failures++;
      $display("FAIL count: got %0d out + %0d dropped, required %0d accepted", out_cnt, dropped, acc_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ks_pipe_sub.md
KS_PIPE_SUB -- requirements
Module: ks_pipe_sub

Interface
REQ-001 Parameter: size, 16, operand width in bits; operand bits are indexed size down to 1.
REQ-002 Parameter: level, 4, number of Kogge-Stone prefix levels; 2**level >= size is required.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operand set on a, b, bin is valid.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 a  input  [size:1]  minuend.
REQ-008 b  input  [size:1]  subtrahend.
REQ-009 bin  input  1  borrow in.
REQ-010 out_valid  output  1  diff, bout (and ovf) hold a valid result.
REQ-011 out_ready  input  1  downstream accepts the result this cycle.
REQ-012 diff  output  [size:1]  (a - b - bin) mod 2**size.
REQ-013 bout  output  1  borrow out; 1 when a < b + bin (unsigned).

Function
REQ-014 Subtraction is computed as a + ~b + ~bin, using bitwise g = a & ~b, p = a ^ ~b, and carry-in g[0] = ~bin.
REQ-015 The carry network is a Kogge-Stone prefix tree with span 2**(m-1) at level m, for m = 1..level.
REQ-016 The pipeline has level+2 register stages: S0 registers p, g and carry-in; S1..S_level each register one prefix level; S_out registers diff, bout and ovf.
REQ-017 diff[x] is p[x] ^ carry[x-1] and bout is ~carry[size].
REQ-018 Each stage carries a valid bit; a stage whose valid bit is 0 is a bubble.
REQ-019 Global advance is en = ~out_valid | out_ready, and in_ready equals en combinationally.
REQ-020 When en = 1, every stage loads from its predecessor and S0 loads in_valid together with the operands; when en = 0, all stages hold.
REQ-021 A transfer occurs on in_valid & in_ready; the result appears with out_valid = 1 exactly level+2 cycles after acceptance when no stall occurs.
REQ-022 Each stall cycle (out_valid & ~out_ready) delays every in-flight result by exactly one cycle; no result is lost or duplicated.
REQ-023 Full throughput is one result per cycle with out_ready held at 1; results leave in acceptance order.
REQ-024 diff, bout and ovf are stable while out_valid = 1 and out_ready = 0.
REQ-025 Operands wrap modulo 2**size; there is no saturation.

Reset
REQ-026 When rst_n = 0 at a clock edge, all stage valid bits clear and out_valid = 0, diff = 0, bout = 0, ovf = 0 on the next cycle.
REQ-027 Reset issued mid-operation discards all in-flight results, and none of them ever appear at the output.
REQ-028 in_ready is 1 during reset; operands presented while rst_n = 0 are not accepted.

Configuration
REQ-029 Macro KS_SUB_OVF_EN defined: the output port ovf (1 bit) exists and is 1 when a and b have different bit size and diff[size] differs from a[size] (two's-complement overflow), registered in S_out together with diff.
REQ-030 Macro KS_SUB_OVF_EN undefined: the ovf port and its logic are absent, and all other behaviour is identical.

Verification
REQ-031 size=16, level=4, out_ready=1: a=0x0005, b=0x0003, bin=0 -> 6 cycles later out_valid=1, diff=0x0002, bout=0.
REQ-032 a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1; a=0x0005, b=0x0005, bin=1 -> diff=0xFFFF, bout=1.
REQ-033 With KS_SUB_OVF_EN defined: a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1; a=0x7FFF, b=0xFFFF -> diff=0x8000, ovf=1.
REQ-034 Back-to-back: stream 8 operand sets (i, 1, 0) for i=1..8 with out_ready low on cycles 7-9 -> results 0..7 appear in order, each held while stalled, and in_ready=0 during the stall.
REQ-035 Reset mid-flight: accept 3 operand sets, then drive rst_n=0 for 1 cycle -> out_valid stays 0 thereafter until a new set is accepted, whose result appears 6 cycles later.
REQ-036 Random: 10k operand sets with random in_valid/out_ready -> every diff/bout matches a reference model and the output count equals the accepted count.
